// File: rtl/dino_pkg.sv
// Shared types and default physics constants for the dino motion slice.
// Imported by the motion controller, its interface and the tick generator users.
package dino_pkg;

  localparam int Y_W = 10;
  localparam int V_W = 8;
  localparam int H_W = 6;

  localparam int DEF_TICK_DIV = 2_000_000;
  localparam int DEF_X_POS    = 30;
  localparam int DEF_GROUND   = 370;
  localparam int DEF_MIN_H    = 200;
  localparam int DEF_V_JUMP   = 9;
  localparam int DEF_GRAV     = 1;
  localparam int DEF_V_MAX    = 8;
  localparam int DEF_HOLD_MAX = 6;
  localparam int DEF_H_STAND  = 40;
  localparam int DEF_H_DUCK   = 24;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_DUCK = 2'd3
  } motion_state_t;

  // Saturate a signed candidate position into [lo, hi] so the screen y never wraps.
  function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W:0] v,
                                             input logic signed [Y_W:0] lo,
                                             input logic signed [Y_W:0] hi);
    if (v <= lo)      return lo[Y_W-1:0];
    else if (v >= hi) return hi[Y_W-1:0];
    else              return v[Y_W-1:0];
  endfunction

endpackage

// File: rtl/dino_motion_if.sv
// Control/status bundle between keyboard decoder, dino motion and sprite/collision logic.
// The slave side is the motion controller; the master side drives keys and reads position.
interface dino_motion_if;
  import dino_pkg::*;

  logic            freeze;
  logic            jump_op;
  logic            jump_hold;
  logic            duck_op;
  logic [Y_W-1:0]  dino_x;
  logic [Y_W-1:0]  dino_y;
  logic [H_W-1:0]  dino_h;
  motion_state_t   state;
  logic            landed;

  modport master (
    output freeze, jump_op, jump_hold, duck_op,
    input  dino_x, dino_y, dino_h, state, landed
  );

  modport slave (
    input  freeze, jump_op, jump_hold, duck_op,
    output dino_x, dino_y, dino_h, state, landed
  );

endinterface

// File: rtl/dino_motion_tick_gen.sv
// Free-running divider producing a one-clk physics tick every TICK_DIV cycles.
// Shared with the obstacle and score blocks so all game objects step together.
module tick_gen #(
  parameter int TICK_DIV = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dino_motion.sv
// Dino vertical motion: velocity/gravity physics, hold-to-extend jump, duck, fast-fall
// and freeze. Physics steps once per tick; all outputs are registered.
module dino_motion
  import dino_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int X_POS    = DEF_X_POS,
  parameter int GROUND   = DEF_GROUND,
  parameter int MIN_H    = DEF_MIN_H,
  parameter int V_JUMP   = DEF_V_JUMP,
  parameter int GRAV     = DEF_GRAV,
  parameter int V_MAX    = DEF_V_MAX,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int H_STAND  = DEF_H_STAND,
  parameter int H_DUCK   = DEF_H_DUCK
) (
  input  logic           clk,
  input  logic           rst,
  dino_motion_if.slave   dm
);

  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic signed [Y_W:0]  GROUND_S = (Y_W+1)'(GROUND);
  localparam logic signed [Y_W:0]  MIN_S    = (Y_W+1)'(MIN_H);
  localparam logic [Y_W-1:0]       GROUND_Y = Y_W'(GROUND);
  localparam logic [Y_W-1:0]       X_Y      = Y_W'(X_POS);
  localparam logic signed [V_W:0]  GRAV_S   = (V_W+1)'(GRAV);
  localparam logic signed [V_W:0]  GRAV2_S  = (V_W+1)'(2 * GRAV);
  localparam logic signed [V_W:0]  VMAX_S   = (V_W+1)'(V_MAX);
  localparam logic [V_W-1:0]       VJ_UP    = V_W'(-V_JUMP);
  localparam logic [HC_W-1:0]      HOLD_LIM = HC_W'(HOLD_MAX);
  localparam logic [H_W-1:0]       HS_V     = H_W'(H_STAND);
  localparam logic [H_W-1:0]       HD_V     = H_W'(H_DUCK);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  motion_state_t        st_q, st_n;
  logic [Y_W-1:0]       y_q, y_n;
  logic [V_W-1:0]       vy_q, vy_n;
  logic [HC_W-1:0]      hc_q, hc_n;
  logic [H_W-1:0]       h_q, h_n;
  logic                 land_q, land_n;

  logic signed [Y_W:0]  y_sum;
  logic signed [V_W:0]  vy_wide, vy_grav, vy_fall, vy_upd;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    st_n    = st_q;
    y_n     = y_q;
    vy_n    = vy_q;
    hc_n    = hc_q;
    land_n  = 1'b0;
    vy_upd  = '0;

    // vy is two's complement, negative = up; widen by one bit before summing.
    vy_wide = $signed({vy_q[V_W-1], vy_q});
    vy_grav = vy_wide + GRAV_S;
    vy_fall = vy_wide + (dm.duck_op ? GRAV2_S : GRAV_S);
    y_sum   = $signed({1'b0, y_q}) + $signed({{(Y_W+1-V_W){vy_q[V_W-1]}}, vy_q});

    if (tick && !dm.freeze) begin
      unique case (st_q)
        ST_RUN, ST_DUCK: begin
          y_n = GROUND_Y;
          if (dm.jump_op) begin
            st_n = ST_RISE;
            vy_n = VJ_UP;
            hc_n = '0;
          end else if (st_q == ST_RUN && dm.duck_op) begin
            st_n = ST_DUCK;
          end else if (st_q == ST_DUCK && !dm.duck_op) begin
            st_n = ST_RUN;
          end
        end

        ST_RISE: begin
          y_n = clamp_y(y_sum, MIN_S, GROUND_S);
          if (y_sum <= MIN_S || dm.duck_op) begin
            // Ceiling hit or duck pressed: kill upward speed and start falling.
            vy_n = '0;
            st_n = ST_FALL;
          end else begin
            // Once the key is released the extension is spent for this jump.
            if (dm.jump_hold && hc_q < HOLD_LIM) begin
              hc_n   = hc_q + 1'b1;
              vy_upd = vy_wide;
            end else begin
              hc_n   = HOLD_LIM;
              vy_upd = vy_grav;
            end
            vy_n = vy_upd[V_W-1:0];
            if (!vy_upd[V_W]) st_n = ST_FALL;
          end
        end

        ST_FALL: begin
          if (y_sum >= GROUND_S) begin
            y_n    = GROUND_Y;
            vy_n   = '0;
            land_n = 1'b1;
            st_n   = dm.duck_op ? ST_DUCK : ST_RUN;
          end else begin
            y_n  = clamp_y(y_sum, MIN_S, GROUND_S);
            vy_n = (vy_fall > VMAX_S) ? VMAX_S[V_W-1:0] : vy_fall[V_W-1:0];
          end
        end

        default: st_n = ST_RUN;
      endcase
    end

    h_n = (st_n == ST_DUCK) ? HD_V : HS_V;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_RUN;
      y_q    <= GROUND_Y;
      vy_q   <= '0;
      hc_q   <= '0;
      h_q    <= HS_V;
      land_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      y_q    <= y_n;
      vy_q   <= vy_n;
      hc_q   <= hc_n;
      h_q    <= h_n;
      land_q <= land_n;
    end
  end

  assign dm.dino_x = X_Y;
  assign dm.dino_y = y_q;
  assign dm.dino_h = h_q;
  assign dm.state  = st_q;
  assign dm.landed = land_q;

endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion with TICK_DIV=4 and MIN_H=300; expected
// trajectories are hand-computed tables. Inputs change and outputs are sampled on negedge.
module tb_dino_motion;
  import dino_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dino_motion_if dif ();

  dino_motion #(.TICK_DIV(TD), .MIN_H(300)) dut (
    .clk (clk),
    .rst (rst),
    .dm  (dif.slave)
  );

  // Tap jump: hold released after the jump tick, apex at 325, lands at tick 20.
  localparam int TAP_N = 20;
  int tap_y [TAP_N] = '{361, 353, 346, 340, 335, 331, 328, 326, 325, 325,
                        326, 328, 331, 335, 340, 346, 353, 361, 369, 370};
  int tap_s [TAP_N] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2,
                        2, 2, 2, 2, 2, 2, 2, 2, 2, 0};

  // Held jump: vy=-9 for 6 ticks, then -8, then ceiling clamp at 300.
  localparam int HELD_N = 8;
  int held_y [HELD_N] = '{361, 352, 343, 334, 325, 316, 307, 300};
  int held_s [HELD_N] = '{1, 1, 1, 1, 1, 1, 1, 2};

  // Fast fall from 300 with vy=0: vy 2,4,6,8,8,...; lands into DUCK.
  localparam int FAST_N = 12;
  int fast_y [FAST_N] = '{300, 302, 306, 312, 320, 328, 336, 344, 352, 360, 368, 370};
  int fast_s [FAST_N] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_wait();
    repeat (TD) @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int y, input int s, input int l);
    check({tag, ".y"},      int'(dif.dino_y), y);
    check({tag, ".state"},  int'(dif.state),  s);
    check({tag, ".landed"}, int'(dif.landed), l);
  endtask

  task automatic run_tap(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      tick_wait();
      check_pos($sformatf("tap[%0d]", i), tap_y[i], tap_s[i], (i == TAP_N - 1) ? 1 : 0);
    end
  endtask

  // Landing pulse must drop one clk later; then realign to the tick phase.
  task automatic after_land(input string tag, input int s);
    @(negedge clk);
    check({tag, ".pulse_end"}, int'(dif.landed), 0);
    check({tag, ".state"},     int'(dif.state),  s);
    repeat (TD - 1) @(negedge clk);
  endtask

  initial begin
    dif.freeze    = 1'b0;
    dif.jump_op   = 1'b0;
    dif.jump_hold = 1'b0;
    dif.duck_op   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.x", int'(dif.dino_x), 30);
    check("rst.h", int'(dif.dino_h), 40);
    check_pos("rst", 370, 0, 0);
    rst = 1'b0;

    tick_wait();
    check_pos("idle", 370, 0, 0);

    // Tap jump
    dif.jump_op   = 1'b1;
    dif.jump_hold = 1'b1;
    tick_wait();
    check_pos("tap.start", 370, 1, 0);
    dif.jump_op   = 1'b0;
    dif.jump_hold = 1'b0;
    run_tap(0, TAP_N - 1);
    check("tap.h", int'(dif.dino_h), 40);
    after_land("tap", 0);

    // Held jump to the ceiling; jump_op left high to confirm it is ignored airborne
    dif.jump_op   = 1'b1;
    dif.jump_hold = 1'b1;
    tick_wait();
    check_pos("held.start", 370, 1, 0);
    for (int i = 0; i < HELD_N; i++) begin
      tick_wait();
      check_pos($sformatf("held[%0d]", i), held_y[i], held_s[i], 0);
    end

    // Reset mid-fall at y=300
    dif.jump_op   = 1'b0;
    dif.jump_hold = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_pos("rst_mid", 370, 0, 0);
    check("rst_mid.h", int'(dif.dino_h), 40);
    rst = 1'b0;

    // Duck on ground, release, re-duck, then jump beats duck
    dif.duck_op = 1'b1;
    tick_wait();
    check_pos("duck.on", 370, 3, 0);
    check("duck.on.h", int'(dif.dino_h), 24);
    dif.duck_op = 1'b0;
    tick_wait();
    check_pos("duck.off", 370, 0, 0);
    check("duck.off.h", int'(dif.dino_h), 40);
    dif.duck_op = 1'b1;
    tick_wait();
    check_pos("duck.again", 370, 3, 0);
    dif.jump_op = 1'b1;
    tick_wait();
    check_pos("duck.jump", 370, 1, 0);
    check("duck.jump.h", int'(dif.dino_h), 40);
    dif.jump_op = 1'b0;
    dif.duck_op = 1'b0;

    // Rise three ticks, freeze for 20 ticks with inputs toggling, then resume
    run_tap(0, 2);
    dif.freeze = 1'b1;
    for (int i = 0; i < 20 * TD; i++) begin
      @(negedge clk);
      check($sformatf("frz[%0d].y", i),      int'(dif.dino_y), 346);
      check($sformatf("frz[%0d].state", i),  int'(dif.state),  1);
      check($sformatf("frz[%0d].landed", i), int'(dif.landed), 0);
      if (i == 20) dif.duck_op = 1'b1;
      if (i == 40) dif.jump_op = 1'b1;
      if (i == 60) begin
        dif.duck_op = 1'b0;
        dif.jump_op = 1'b0;
      end
    end
    dif.freeze = 1'b0;
    run_tap(3, TAP_N - 1);
    after_land("frz", 0);

    // Held jump to ceiling, then fast fall with duck, landing into DUCK
    dif.jump_op   = 1'b1;
    dif.jump_hold = 1'b1;
    tick_wait();
    check_pos("ff.start", 370, 1, 0);
    dif.jump_op = 1'b0;
    for (int i = 0; i < HELD_N; i++) begin
      tick_wait();
      check_pos($sformatf("ff.rise[%0d]", i), held_y[i], held_s[i], 0);
    end
    dif.jump_hold = 1'b0;
    dif.duck_op   = 1'b1;
    for (int i = 0; i < FAST_N; i++) begin
      tick_wait();
      check_pos($sformatf("ff.fall[%0d]", i), fast_y[i], fast_s[i], (i == FAST_N - 1) ? 1 : 0);
    end
    check("ff.h", int'(dif.dino_h), 24);
    after_land("ff", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
